iddmm_host: RTL and testbench

Requester-side sequencer for the word-serial Montgomery multiplier. It accepts one full-width job (X, Y, M), writes the operands word by word into the multiplier's operand RAMs, and issues a one-cycle `task_req` rising edge. It then collects the N result words returned under `task_grant`/`task_end`, assembles them into one K*N-bit result, and presents that result on a valid/ready port. It sits between the top-level job dispatcher and the multiplier control block.

---
 rtl/iddmm_host.sv | 167 ++++++++++++++++
 tb/tb_iddmm_host.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iddmm_host.sv
// Requester-side sequencer for the word-serial Montgomery multiplier: loads operands,
// pulses task_req, gathers the returned result words and hands back one wide result.
module iddmm_host #(
    parameter int K       = 256,
    parameter int N       = 16,
    parameter int ADDR_W  = $clog2(N),
    parameter int TIMEOUT = 65535,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [K*N-1:0]    job_x,
    input  logic [K*N-1:0]    job_y,
    input  logic [K*N-1:0]    job_m,
    output logic              op_wr_en,
    output logic [ADDR_W-1:0] op_wr_addr,
    output logic [K-1:0]      op_wr_x,
    output logic [K-1:0]      op_wr_y,
    output logic [K-1:0]      op_wr_m,
    output logic              task_req,
    input  logic              task_grant,
    input  logic              task_end,
    input  logic [K-1:0]      task_res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [K*N-1:0]    res_data,
    output logic              res_err,
    output logic              busy
);

    // Word counter must reach N+1 so an over-long response is still flagged.
    localparam int CNT_W = $clog2(N + 2);

    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, COLLECT, DONE} state_t;

    state_t             state_q;
    logic [K*N-1:0]     x_q, y_q, m_q;
    logic [K*N-1:0]     res_data_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [K-1:0]       wr_x_q, wr_y_q, wr_m_q;
    logic               op_wr_en_q, task_req_q, res_valid_q, res_err_q, busy_q, job_ready_q;
    logic               accept, timed_out;

    always_comb begin
        addr_d    = addr_q + ADDR_W'(1);
        cnt_d     = (cnt_q > CNT_W'(N)) ? cnt_q : cnt_q + CNT_W'(1);
        to_d      = to_q + TO_W'(1);
        accept    = job_valid && job_ready_q;
        timed_out = (to_d == TO_W'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            m_q         <= '0;
            res_data_q  <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_m_q      <= '0;
            op_wr_en_q  <= 1'b0;
            task_req_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            job_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    job_ready_q <= 1'b1;
                    if (accept) begin
                        x_q         <= job_x;
                        y_q         <= job_y;
                        m_q         <= job_m;
                        res_data_q  <= '0;
                        res_err_q   <= 1'b0;
                        cnt_q       <= '0;
                        to_q        <= '0;
                        addr_q      <= '0;
                        wr_x_q      <= job_x[K-1:0];
                        wr_y_q      <= job_y[K-1:0];
                        wr_m_q      <= job_m[K-1:0];
                        op_wr_en_q  <= 1'b1;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    if (addr_q == ADDR_W'(N - 1)) begin
                        op_wr_en_q <= 1'b0;
                        addr_q     <= '0;
                        wr_x_q     <= '0;
                        wr_y_q     <= '0;
                        wr_m_q     <= '0;
                        task_req_q <= 1'b1;
                        state_q    <= REQ;
                    end else begin
                        addr_q <= addr_d;
                        wr_x_q <= x_q[int'(addr_d)*K +: K];
                        wr_y_q <= y_q[int'(addr_d)*K +: K];
                        wr_m_q <= m_q[int'(addr_d)*K +: K];
                    end
                end
                REQ: begin
                    task_req_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT, COLLECT: begin
                    // A terminating grant wins over a simultaneous timeout.
                    to_q <= to_d;
                    if (task_grant) begin
                        if (cnt_q < CNT_W'(N)) begin
                            res_data_q[int'(cnt_q)*K +: K] <= task_res;
                        end
                        cnt_q <= cnt_d;
                        if (task_end) begin
                            res_valid_q <= 1'b1;
                            res_err_q   <= (cnt_d != CNT_W'(N));
                            state_q     <= DONE;
                        end else if (timed_out) begin
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end else if (timed_out) begin
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        job_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign job_ready  = job_ready_q;
    assign op_wr_en   = op_wr_en_q;
    assign op_wr_addr = addr_q;
    assign op_wr_x    = wr_x_q;
    assign op_wr_y    = wr_y_q;
    assign op_wr_m    = wr_m_q;
    assign task_req   = task_req_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_iddmm_host.sv
// Directed bench for iddmm_host with a small job/result scoreboard checked every cycle.
module tb_iddmm_host;

    localparam int K       = 8;
    localparam int N       = 4;
    localparam int TIMEOUT = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid, job_ready;
    logic [31:0]   job_x, job_y, job_m;
    logic          op_wr_en;
    logic [1:0]    op_wr_addr;
    logic [7:0]    op_wr_x, op_wr_y, op_wr_m;
    logic          task_req, task_grant, task_end;
    logic [7:0]    task_res;
    logic          res_valid, res_ready, res_err, busy;
    logic [31:0]   res_data;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] m;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } res_t;

    wr_t  expWrites[$];
    res_t expResult[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   reqPulses = 0;
    int   reqBase = 0;

    iddmm_host #(.K(K), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_y(job_y), .job_m(job_m),
        .op_wr_en(op_wr_en), .op_wr_addr(op_wr_addr),
        .op_wr_x(op_wr_x), .op_wr_y(op_wr_y), .op_wr_m(op_wr_m),
        .task_req(task_req), .task_grant(task_grant), .task_end(task_end), .task_res(task_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Result model: the first N returned words land LSW-first, anything else is an error.
    function automatic logic [31:0] modelData(input int nWords, input bit silent);
        logic [31:0] d;
        d = '0;
        if (!silent)
            for (int i = 0; i < nWords && i < N; i++) d[8*i +: 8] = 8'(17 * (i + 1));
        return d;
    endfunction

    function automatic bit modelErr(input int nWords, input bit silent);
        return silent || (nWords != N);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (op_wr_en) begin
                if (expWrites.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL wr_unexpected: got addr %0d, expected no write", op_wr_addr);
                end else begin
                    wr_t w;
                    w = expWrites.pop_front();
                    checkOutput("wr_word", {6'd0, op_wr_addr, op_wr_x, op_wr_y, op_wr_m}, 32'(w));
                end
            end
            if (task_req) reqPulses++;
            if (res_valid) begin
                checkOutput("job_ready_in_done", 32'(job_ready), 32'd0);
                if (expResult.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL res_unexpected: got res_valid 1, expected 0");
                end else begin
                    checkOutput("res_data_model", res_data, expResult[0].data);
                    checkOutput("res_err_model", 32'(res_err), 32'(expResult[0].err));
                    if (res_ready) void'(expResult.pop_front());
                end
            end
        end
    end

    task automatic startJob(input logic [31:0] x, input logic [31:0] y, input logic [31:0] m);
        int cyc;
        bit preOffered;
        for (int i = 0; i < N; i++)
            expWrites.push_back('{addr: 2'(i), x: x[8*i +: 8], y: y[8*i +: 8], m: m[8*i +: 8]});
        preOffered = job_valid;
        job_x = x;
        job_y = y;
        job_m = m;
        job_valid = 1'b1;
        cyc = 0;
        while (!job_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("job_ready_before_accept", 32'(job_ready), 32'd1);
        if (preOffered) checkOutput("b2b_accept_wait", 32'(cyc), 32'd0);
        @(posedge clk); #1;
        job_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("job_ready_after_accept", 32'(job_ready), 32'd0);
        reqBase = reqPulses;
        cyc = 0;
        while (!task_req && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("req_latency", 32'(cyc), 32'(N));
        @(posedge clk); #1;
        checkOutput("req_pulse_width", 32'(task_req), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [31:0] m,
                                 input int nWords, input int gap, input bit silent,
                                 input int hold, input bit offerNext,
                                 input logic [31:0] expData, input bit expErr);
        int cyc;
        expResult.push_back('{data: modelData(nWords, silent), err: modelErr(nWords, silent)});
        startJob(x, y, m);
        if (silent) begin
            cyc = 0;
            while (!res_valid && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            checkOutput("timeout_latency", 32'(cyc), 32'(TIMEOUT));
        end else begin
            for (int w = 0; w < nWords; w++) begin
                task_grant = 1'b1;
                task_res   = 8'(17 * (w + 1));
                task_end   = (w == nWords - 1);
                @(posedge clk); #1;
                task_grant = 1'b0;
                task_end   = 1'b0;
                if (w != nWords - 1) repeat (gap) begin @(posedge clk); #1; end
            end
            checkOutput("valid_latency", 32'(res_valid), 32'd1);
        end
        checkOutput("res_data_literal", res_data, expData);
        checkOutput("res_err_literal", 32'(res_err), 32'(expErr));
        if (offerNext) job_valid = 1'b1;
        repeat (hold) begin @(posedge clk); #1; end
        checkOutput("valid_held", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checkOutput("valid_after_handshake", 32'(res_valid), 32'd0);
        checkOutput("job_ready_after_handshake", 32'(job_ready), 32'd1);
        checkOutput("busy_after_handshake", 32'(busy), 32'd0);
        checkOutput("req_count", 32'(reqPulses - reqBase), 32'd1);
    endtask

    task automatic checkResetValues(input logic expReady);
        checkOutput("rst_job_ready", 32'(job_ready), 32'(expReady));
        checkOutput("rst_op_wr", {15'd0, op_wr_en, 6'd0, op_wr_addr, op_wr_x}, 32'd0);
        checkOutput("rst_op_ym", {16'd0, op_wr_y, op_wr_m}, 32'd0);
        checkOutput("rst_flags", {28'd0, task_req, res_valid, res_err, busy}, 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        job_valid = 1'b0;
        job_x = '0;
        job_y = '0;
        job_m = '0;
        task_grant = 1'b0;
        task_end = 1'b0;
        task_res = '0;
        res_ready = 1'b0;
        @(posedge clk); #1;
        checkResetValues(1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_job_ready", 32'(job_ready), 32'd1);

        $display("[TB] back-to-back grants");
        applyStimulus(32'h04030201, 32'h08070605, 32'h0C0B0A09, 4, 0, 1'b0, 0, 1'b0, 32'h44332211, 1'b0);
        $display("[TB] gapped grants");
        applyStimulus(32'h04030201, 32'h08070605, 32'h0C0B0A09, 4, 2, 1'b0, 0, 1'b0, 32'h44332211, 1'b0);
        $display("[TB] short response");
        applyStimulus(32'h04030201, 32'h08070605, 32'h0C0B0A09, 3, 0, 1'b0, 0, 1'b0, 32'h00332211, 1'b1);
        $display("[TB] long response");
        applyStimulus(32'hA1B2C3D4, 32'h55AA33CC, 32'hFF00EE11, 5, 1, 1'b0, 0, 1'b0, 32'h44332211, 1'b1);
        $display("[TB] silent responder");
        applyStimulus(32'h04030201, 32'h08070605, 32'h0C0B0A09, 0, 0, 1'b1, 0, 1'b0, 32'h00000000, 1'b1);
        $display("[TB] held result with queued job");
        applyStimulus(32'h04030201, 32'h08070605, 32'h0C0B0A09, 4, 0, 1'b0, 10, 1'b1, 32'h44332211, 1'b0);
        applyStimulus(32'h04030201, 32'h08070605, 32'h0C0B0A09, 4, 1, 1'b0, 0, 1'b0, 32'h44332211, 1'b0);

        $display("[TB] reset during collect");
        startJob(32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C);
        for (int w = 0; w < 2; w++) begin
            task_grant = 1'b1;
            task_res   = 8'(17 * (w + 1));
            @(posedge clk); #1;
            task_grant = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checkResetValues(1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_after_reset", 32'(job_ready), 32'd1);
        applyStimulus(32'h04030201, 32'h08070605, 32'h0C0B0A09, 4, 0, 1'b0, 0, 1'b0, 32'h44332211, 1'b0);

        repeat (3) @(posedge clk);
        checkOutput("writes_drained", 32'(expWrites.size()), 32'd0);
        checkOutput("results_drained", 32'(expResult.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
